div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port iRst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port iStart, input, 1 bit: a one-cycle request to begin a division, honoured only in IDLE.
REQ-004 SHALL have port iSigned, input, 1 bit: 1 = IDIV (two's complement), 0 = DIV.
REQ-005 SHALL have port iW, input, 1 bit: 0 = byte (AX / r8), 1 = word (DX:AX / r16).
REQ-006 SHALL have port iDividend, input, 32 bits: DX:AX; byte mode uses [15:0] only.
REQ-007 SHALL have port iDivisor, input, 16 bits: the divisor; byte mode uses [7:0] only.
REQ-008 SHALL have port oBusy, output, 1 bit: high from the cycle after an accepted start until oDone is raised.
REQ-009 SHALL have port oDone, output, 1 bit: a one-cycle completion pulse.
REQ-010 SHALL have port oQuot, output, 16 bits: the quotient (AL or AX); upper byte is 0 in byte mode.
REQ-011 SHALL have port oRem, output, 16 bits: the remainder (AH or DX); upper byte is 0 in byte mode.
REQ-012 SHALL have port oDivErr, output, 1 bit: divide error (INT 0 request), valid while oDone is high.

Function
REQ-013 SHALL use the states IDLE, CALC, FIX and DONE.
REQ-014 SHALL, in IDLE with iStart=1, register all operands and convert the dividend and divisor to magnitudes when iSigned=1, then enter CALC.
REQ-015 SHALL flag an error at start when the divisor magnitude is 0, or when the upper half of the dividend magnitude (bits [15:8] byte, [31:16] word) is >= the divisor magnitude.
REQ-016 SHALL, in CALC, perform one restoring shift-subtract step per cycle for N cycles (N=8 byte, N=16 word), counting with a down-counter, and then enter FIX.
REQ-017 SHALL, in FIX, negate the quotient when the dividend and divisor signs differ and give the remainder the sign of the dividend (signed mode only).
REQ-018 SHALL, in FIX for signed mode, also flag an error when the quotient magnitude is >= 2^(N-1) (8086 rule: quotients -128 and -32768 raise an error).
REQ-019 SHALL, in DONE, assert oDone for exactly one cycle and then return to IDLE.
REQ-020 SHALL have a fixed latency: the start is sampled at edge k and oDone is high in the cycle after edge k+N+2, including error cases (CALC runs but its result is discarded).
REQ-021 SHALL update oQuot and oRem only on a non-error completion; on error both keep their previous values and oDivErr=1.
REQ-022 SHALL hold oDivErr from DONE until the next accepted start.
REQ-023 SHALL ignore iStart while oBusy=1 or in DONE.
REQ-024 SHALL ignore operand input changes after the start has been sampled.
REQ-025 SHALL have results that feed the flag stage with flag-select "div"; this block produces no arithmetic flags.

Reset
REQ-026 SHALL, with iRst=1 at any edge (including mid-CALC), go to IDLE and set oBusy=0, oDone=0, oDivErr=0, oQuot=0x0000, oRem=0x0000 and the counter to 0.
REQ-027 SHALL take reset priority over iStart in the same cycle.
REQ-028 SHALL treat the first iStart after reset deassertion as a normal start.

Structure
REQ-029 SHALL place the state encoding, the N_BYTE=8 and N_WORD=16 constants, and the counter width in a shared package div_pkg.
REQ-030 SHALL implement one restoring step (partial remainder, divisor -> next remainder, quotient bit) as the combinational sub-module div_step, instantiated once.

Verification
REQ-031 SHALL cover: unsigned byte, iDividend=0x0064, iDivisor=0x07 -> oQuot=0x000E, oRem=0x0002, oDivErr=0, oDone 10 cycles after start.
REQ-032 SHALL cover: unsigned word, 0x0001_0000 / 0x0002 -> oQuot=0x8000, oRem=0x0000, oDone 18 cycles after start.
REQ-033 SHALL cover: signed byte, 0xFFF9 (-7) / 0x02 -> oQuot=0x00FD (-3), oRem=0x00FF (-1); and 0x0007 / 0xFE -> oQuot=0x00FD, oRem=0x0001.
REQ-034 SHALL cover the error cases, each -> oDivErr=1 with prior oQuot and oRem unchanged:
  - divisor 0x0000 in word mode;
  - unsigned byte 0x0100 / 0x01;
  - signed byte 0xFF80 / 0x01 (quotient -128).
REQ-035 SHALL cover: iRst=1 at cycle 5 of a word divide -> next cycle oBusy=0, all outputs 0, no oDone; a following start of 0x0064 / 0x07 completes correctly.
REQ-036 SHALL cover: a second iStart while busy -> ignored, exactly one oDone pulse with the first division's result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the 8086-style DIV/IDIV unit.
package div_pkg;
    localparam int N_BYTE = 8;
    localparam int N_WORD = 16;
    localparam int CNT_W  = $clog2(N_WORD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Two's-complement negate when neg is set (magnitude of a negative operand, or re-signing a result).
    function automatic logic [15:0] cond_neg16(input logic [15:0] val, input logic neg);
        return neg ? (16'd0 - val) : val;
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial remainder and try the divisor.
module div_step (
    input  logic [15:0] rem_in,
    input  logic        bit_in,
    input  logic [15:0] divisor,
    output logic [15:0] rem_out,
    output logic        q_bit
);
    logic [16:0] shifted;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {1'b0, divisor});
        // When the subtraction succeeds the result is below the divisor, so 16 bits hold it exactly.
        rem_out = q_bit ? (shifted[15:0] - divisor) : shifted[15:0];
    end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/IDIV unit: byte (AX / r8) or word (DX:AX / r16), fixed latency, 8086 divide-error rules.
module div_unit
    import div_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic        iSigned,
    input  logic        iW,
    input  logic [31:0] iDividend,
    input  logic [15:0] iDivisor,
    output logic        oBusy,
    output logic        oDone,
    output logic [15:0] oQuot,
    output logic [15:0] oRem,
    output logic        oDivErr
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rem_q, rem_d;
    logic [15:0]      quo_q, quo_d;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [15:0]      dsr_q, dsr_d;
    logic             w_q, w_d, sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, err_q, err_d;
    logic [15:0]      quot_res_q, quot_res_d, rem_res_q, rem_res_d;
    logic             div_err_q, div_err_d;

    logic             dvd_neg, dsr_neg, start_err;
    logic [31:0]      dvd_mag;
    logic [15:0]      dsr_mag, dvd_hi, dvd_lo;

    always_comb begin
        dvd_neg = iSigned & (iW ? iDividend[31] : iDividend[15]);
        dsr_neg = iSigned & (iW ? iDivisor[15] : iDivisor[7]);
        if (iW) begin
            dvd_mag = dvd_neg ? (32'd0 - iDividend) : iDividend;
            dsr_mag = cond_neg16(iDivisor, dsr_neg);
            dvd_hi  = dvd_mag[31:16];
            dvd_lo  = dvd_mag[15:0];
        end else begin
            dvd_mag = {16'd0, cond_neg16(iDividend[15:0], dvd_neg)};
            dsr_mag = {8'd0, 8'(cond_neg16({8'd0, iDivisor[7:0]}, dsr_neg))};
            dvd_hi  = {8'd0, dvd_mag[15:8]};
            dvd_lo  = {dvd_mag[7:0], 8'd0};
        end
        start_err = (dsr_mag == 16'd0) || (dvd_hi >= dsr_mag);
    end

    logic [15:0] step_rem;
    logic        step_q;

    div_step u_step (
        .rem_in  (rem_q),
        .bit_in  (quo_q[15]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    logic [15:0] quo_mag, quot_fin, rem_fin;
    logic        fix_err;

    always_comb begin
        quo_mag  = w_q ? quo_q : {8'd0, quo_q[7:0]};
        quot_fin = cond_neg16(quo_mag, qneg_q);
        rem_fin  = cond_neg16(rem_q, rneg_q);
        if (!w_q) begin
            quot_fin[15:8] = 8'd0;
            rem_fin[15:8]  = 8'd0;
        end
        // Quotient magnitudes of 2^(N-1) and above do not fit a signed result, -2^(N-1) included.
        fix_err = err_q | (sgn_q & (w_q ? quo_q[15] : quo_q[7]));
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dsr_d      = dsr_q;
        w_d        = w_q;
        sgn_d      = sgn_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        err_d      = err_q;
        quot_res_d = quot_res_q;
        rem_res_d  = rem_res_q;
        div_err_d  = div_err_q;

        unique case (state_q)
            IDLE: begin
                if (iStart) begin
                    rem_d     = dvd_hi;
                    quo_d     = dvd_lo;
                    dsr_d     = dsr_mag;
                    w_d       = iW;
                    sgn_d     = iSigned;
                    qneg_d    = dvd_neg ^ dsr_neg;
                    rneg_d    = dvd_neg;
                    err_d     = start_err;
                    div_err_d = 1'b0;
                    cnt_d     = iW ? CNT_W'(N_WORD) : CNT_W'(N_BYTE);
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    rem_d = step_rem;
                    quo_d = {quo_q[14:0], step_q};
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                div_err_d = fix_err;
                if (!fix_err) begin
                    quot_res_d = quot_fin;
                    rem_res_d  = rem_fin;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dsr_q      <= '0;
            w_q        <= 1'b0;
            sgn_q      <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            err_q      <= 1'b0;
            quot_res_q <= '0;
            rem_res_q  <= '0;
            div_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dsr_q      <= dsr_d;
            w_q        <= w_d;
            sgn_q      <= sgn_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            err_q      <= err_d;
            quot_res_q <= quot_res_d;
            rem_res_q  <= rem_res_d;
            div_err_q  <= div_err_d;
        end
    end

    assign oBusy   = (state_q == CALC) || (state_q == FIX);
    assign oDone   = (state_q == DONE);
    assign oQuot   = quot_res_q;
    assign oRem    = rem_res_q;
    assign oDivErr = div_err_q;
endmodule
